// File: rtl/inv_lower_2_pkg.sv
// Shared constants, FSM state type and saturation helper for inv_lower_2.
package inv_lower_2_pkg;

  localparam int W    = 32;
  localparam int FRAC = 16;

  localparam logic [W-1:0] Q_MAX = 32'h7FFF_FFFF;
  localparam logic [W-1:0] Q_MIN = 32'h8000_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DIV,
    ST_MUL1,
    ST_MUL2,
    ST_DONE
  } state_t;

  // Clamp a 64-bit signed intermediate into the signed 32-bit Q16.16 range.
  function automatic logic [W-1:0] sat32(input logic signed [63:0] v);
    if (v > 64'sd2147483647)
      return Q_MAX;
    else if (v < -64'sd2147483648)
      return Q_MIN;
    else
      return v[W-1:0];
  endfunction

endpackage

// File: rtl/recip_q16.sv
// Sequential Q16.16 reciprocal r = floor(2^32 / x), radix-2 restoring, 32 iterations.
// Non-positive x, x==1 and x==2 saturate to Q_MAX.
module recip_q16
  import inv_lower_2_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         clk_en,
  input  logic         start,
  input  logic [W-1:0] x,
  output logic         done,
  output logic [W-1:0] r
);

  logic [W-1:0] d;
  logic [W-1:0] rem;
  logic [W-1:0] q;
  logic [4:0]   cnt;
  logic         busy;
  logic         sat;

  logic [W:0]   rem_sh;
  logic         qbit;
  logic [W-1:0] rem_nxt;

  // One restoring step; the leading dividend bit 2^32 is pre-consumed by starting rem at 1
  // (x==1, the only case where that bit yields a quotient digit, is saturated separately).
  always_comb begin
    rem_sh  = {rem, 1'b0};
    qbit    = (rem_sh >= {1'b0, d});
    rem_nxt = qbit ? 32'(rem_sh - {1'b0, d}) : rem_sh[W-1:0];
  end

  // Divider state: load on start, then iterate once per enabled edge for 32 edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d    <= '0;
      rem  <= '0;
      q    <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      sat  <= 1'b0;
    end else if (clk_en) begin
      if (start && !busy) begin
        d    <= x;
        rem  <= 32'd1;
        q    <= '0;
        cnt  <= '0;
        busy <= 1'b1;
        sat  <= ($signed(x) <= 0) || (x == 32'd1);
      end else if (busy) begin
        rem <= rem_nxt;
        q   <= {q[W-2:0], qbit};
        cnt <= cnt + 5'd1;
        if (cnt == 5'd31)
          busy <= 1'b0;
      end
    end
  end

  // done marks the cycle whose enabled edge completes the final iteration.
  always_comb begin
    done = busy && (cnt == 5'd31);
    r    = (sat || q[W-1]) ? Q_MAX : q;
  end

endmodule

// File: rtl/inv_lower_2.sv
// 2x2 lower-triangular Q16.16 inverse: Z = [1/S11 0; -S21/(S11*S22) 1/S22].
// Optional macro INV_LOWER_2_DIVZ_EN adds Z_divz (non-positive diagonal flag).
module inv_lower_2
  import inv_lower_2_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_en,
  input  logic [95:0] S,
  input  logic        S_valid,
  output logic [95:0] Z,
  output logic        Z_valid
`ifdef INV_LOWER_2_DIVZ_EN
  ,
  output logic        Z_divz
`endif
);

  state_t              state;
  state_t              nxt;
  logic                prev_valid;
  logic                start;
  logic signed [W-1:0] s21_l;
  logic signed [W-1:0] t;
  logic [W-1:0]        z21;
  logic [W-1:0]        r11;
  logic [W-1:0]        r22;
  logic                done11;
  logic                done22;
  logic signed [63:0]  mul1;
  logic signed [63:0]  mul2;
`ifdef INV_LOWER_2_DIVZ_EN
  logic                divz_l;
`endif

  recip_q16 u_r11 (
    .clk    (clk),
    .rst    (rst),
    .clk_en (clk_en),
    .start  (start),
    .x      (S[31:0]),
    .done   (done11),
    .r      (r11)
  );

  recip_q16 u_r22 (
    .clk    (clk),
    .rst    (rst),
    .clk_en (clk_en),
    .start  (start),
    .x      (S[95:64]),
    .done   (done22),
    .r      (r22)
  );

  // Start detection and next-state logic.
  always_comb begin
    start = (state == ST_IDLE) && S_valid && !prev_valid;
    nxt   = state;
    case (state)
      ST_IDLE: if (start) nxt = ST_DIV;
      ST_DIV:  if (done11 && done22) nxt = ST_MUL1;
      ST_MUL1: nxt = ST_MUL2;
      ST_MUL2: nxt = ST_DONE;
      ST_DONE: nxt = ST_IDLE;
      default: nxt = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= ST_IDLE;
    else if (clk_en)
      state <= nxt;
  end

  // 64-bit signed products for the two multiply stages.
  always_comb begin
    mul1 = 64'(s21_l) * 64'(signed'(r11));
    mul2 = 64'(t) * 64'(signed'(r22));
  end

  // Edge detector, input latch, multiply stages and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_valid <= 1'b0;
      s21_l      <= '0;
      t          <= '0;
      z21        <= '0;
      Z          <= '0;
      Z_valid    <= 1'b0;
`ifdef INV_LOWER_2_DIVZ_EN
      divz_l     <= 1'b0;
      Z_divz     <= 1'b0;
`endif
    end else if (clk_en) begin
      prev_valid <= S_valid;
      Z_valid    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            s21_l  <= signed'(S[63:32]);
`ifdef INV_LOWER_2_DIVZ_EN
            divz_l <= ($signed(S[31:0]) <= 0) || ($signed(S[95:64]) <= 0);
`endif
          end
        end
        ST_MUL1: t   <= signed'(sat32(mul1 >>> FRAC));
        ST_MUL2: z21 <= sat32(-(mul2 >>> FRAC));
        ST_DONE: begin
          Z       <= {r22, z21, r11};
          Z_valid <= 1'b1;
`ifdef INV_LOWER_2_DIVZ_EN
          Z_divz  <= divz_l;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inv_lower_2.sv
// Directed self-checking bench for inv_lower_2 (Z_divz checks only with INV_LOWER_2_DIVZ_EN).
module tb_inv_lower_2;

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_en;
  logic [95:0] S;
  logic        S_valid;
  logic [95:0] Z;
  logic        Z_valid;
`ifdef INV_LOWER_2_DIVZ_EN
  logic        Z_divz;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [95:0] VEC2 = 96'h0000_2000_0000_1000_0000_4000;
  localparam logic [95:0] EXP2 = 96'h0008_0000_FFFE_0000_0004_0000;
  localparam logic [95:0] VEC3 = 96'h0002_aa0a_0000_1ff2_0001_ff25;
  localparam logic [95:0] EXP3 = 96'h0000_6016_FFFF_FA00_0000_8036;
  localparam logic [95:0] VEC5 = 96'h0001_0000_0001_0000_0000_0000;
  localparam logic [95:0] EXP5 = 96'h0001_0000_8000_0001_7FFF_FFFF;

  always #5 clk = ~clk;

  inv_lower_2 dut (
    .clk     (clk),
    .rst     (rst),
    .clk_en  (clk_en),
    .S       (S),
    .S_valid (S_valid),
    .Z       (Z),
    .Z_valid (Z_valid)
`ifdef INV_LOWER_2_DIVZ_EN
    ,
    .Z_divz  (Z_divz)
`endif
  );

  task step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    S_valid = 1'b0;
    for (int i = 0; i < n; i++) step;
  endtask

  // Raise S_valid (step 1 is the accepting edge), hold it for 'hold' edges, optionally
  // disable clk_en for edges gap_at+1..gap_at+gap_len; report first Z_valid step and pulse count.
  task automatic run_job(input logic [95:0] sv, input int hold, input int gap_at,
                         input int gap_len, input int window, output int lat,
                         output int pulses, output logic [95:0] zc, output logic dz);
    lat = -1; pulses = 0; zc = '0; dz = 1'b0;
    S = sv;
    S_valid = 1'b1;
    for (int n = 1; n <= window; n++) begin
      clk_en = (n > gap_at && n <= gap_at + gap_len) ? 1'b0 : 1'b1;
      step;
      if (n == hold) S_valid = 1'b0;
      if (Z_valid) begin
        pulses++;
        if (lat < 0) begin
          lat = n;
          zc  = Z;
`ifdef INV_LOWER_2_DIVZ_EN
          dz  = Z_divz;
`endif
        end
      end
    end
    clk_en = 1'b1;
  endtask

  task automatic test_reset;
    int pulses;
    rst = 1'b1; clk_en = 1'b1; S_valid = 1'b0; S = '0;
    step; step; step;
    n_cmp++; if (Z !== '0) begin n_bad++; $display("FAIL reset_z: got %h expected 0", Z); end
    n_cmp++; if (Z_valid !== 1'b0) begin n_bad++; $display("FAIL reset_zvalid: got %b expected 0", Z_valid); end
`ifdef INV_LOWER_2_DIVZ_EN
    n_cmp++; if (Z_divz !== 1'b0) begin n_bad++; $display("FAIL reset_divz: got %b expected 0", Z_divz); end
`endif
    rst = 1'b0;
    S = VEC2;
    pulses = 0;
    for (int i = 0; i < 45; i++) begin
      step;
      if (Z_valid) pulses++;
    end
    n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL idle_no_valid: got %0d pulses expected 0", pulses); end
  endtask

  task automatic test_basic;
    int lat, pulses; logic [95:0] zc; logic dz;
    idle(2);
    run_job(VEC2, 6, 0, 0, 60, lat, pulses, zc, dz);
    n_cmp++; if (lat !== 36) begin n_bad++; $display("FAIL basic_latency: got %0d expected 36", lat); end
    n_cmp++; if (pulses !== 1) begin n_bad++; $display("FAIL basic_pulses: got %0d expected 1", pulses); end
    n_cmp++; if (zc !== EXP2) begin n_bad++; $display("FAIL basic_z: got %h expected %h", zc, EXP2); end
    n_cmp++; if (Z !== EXP2) begin n_bad++; $display("FAIL basic_z_hold: got %h expected %h", Z, EXP2); end
`ifdef INV_LOWER_2_DIVZ_EN
    n_cmp++; if (dz !== 1'b0) begin n_bad++; $display("FAIL basic_divz: got %b expected 0", dz); end
`endif
  endtask

  task automatic test_vector3;
    int lat, pulses; logic [95:0] zc; logic dz; logic [31:0] f;
    idle(2);
    run_job(VEC3, 1, 0, 0, 45, lat, pulses, zc, dz);
    n_cmp++; if (lat !== 36) begin n_bad++; $display("FAIL v3_latency: got %0d expected 36", lat); end
    f = zc[31:0];
    n_cmp++; if (f !== 32'h0000_8036) begin n_bad++; $display("FAIL v3_z11: got %h expected 00008036", f); end
    f = zc[95:64];
    n_cmp++; if (f !== 32'h0000_6016) begin n_bad++; $display("FAIL v3_z22: got %h expected 00006016", f); end
    f = zc[63:32];
    n_cmp++; if (f !== 32'hFFFF_FA00) begin n_bad++; $display("FAIL v3_z21: got %h expected fffffa00", f); end
  endtask

  task automatic test_busy_ignore;
    int lat, pulses; logic [95:0] zc;
    idle(2);
    lat = -1; pulses = 0; zc = '0;
    S = VEC2; S_valid = 1'b1;
    for (int n = 1; n <= 60; n++) begin
      step;
      if (n == 3) begin S_valid = 1'b0; S = VEC3; end
      if (n == 5) S_valid = 1'b1;
      if (n == 10) S_valid = 1'b0;
      if (n == 20) S_valid = 1'b1;
      if (n == 30) begin S_valid = 1'b0; S = VEC5; end
      if (Z_valid) begin
        pulses++;
        if (lat < 0) begin lat = n; zc = Z; end
      end
    end
    n_cmp++; if (pulses !== 1) begin n_bad++; $display("FAIL busy_pulses: got %0d expected 1", pulses); end
    n_cmp++; if (lat !== 36) begin n_bad++; $display("FAIL busy_latency: got %0d expected 36", lat); end
    n_cmp++; if (zc !== EXP2) begin n_bad++; $display("FAIL busy_z: got %h expected %h", zc, EXP2); end
  endtask

  task automatic test_back_to_back;
    int lat, pulses; logic [95:0] zc; logic dz;
    idle(2);
    run_job(VEC3, 100, 0, 0, 80, lat, pulses, zc, dz);
    n_cmp++; if (pulses !== 1) begin n_bad++; $display("FAIL held_pulses: got %0d expected 1", pulses); end
    idle(1);
    run_job(VEC2, 2, 0, 0, 40, lat, pulses, zc, dz);
    n_cmp++; if (lat !== 36) begin n_bad++; $display("FAIL b2b_latency: got %0d expected 36", lat); end
    n_cmp++; if (zc !== EXP2) begin n_bad++; $display("FAIL b2b_z: got %h expected %h", zc, EXP2); end
  endtask

  task automatic test_divz_clken;
    int lat, pulses; logic [95:0] zc; logic dz;
    idle(2);
    run_job(VEC5, 2, 10, 10, 70, lat, pulses, zc, dz);
    n_cmp++; if (lat !== 46) begin n_bad++; $display("FAIL gap_latency: got %0d expected 46", lat); end
    n_cmp++; if (pulses !== 1) begin n_bad++; $display("FAIL gap_pulses: got %0d expected 1", pulses); end
    n_cmp++; if (zc !== EXP5) begin n_bad++; $display("FAIL divz_z: got %h expected %h", zc, EXP5); end
`ifdef INV_LOWER_2_DIVZ_EN
    n_cmp++; if (dz !== 1'b1) begin n_bad++; $display("FAIL divz_flag: got %b expected 1", dz); end
`endif
  endtask

  task automatic test_rst_abort;
    int lat, pulses; logic [95:0] zc; logic dz;
    idle(2);
    S = VEC3; S_valid = 1'b1;
    for (int n = 1; n <= 10; n++) step;
    S_valid = 1'b0;
    rst = 1'b1;
    #2;
    n_cmp++; if (Z !== '0) begin n_bad++; $display("FAIL abort_z: got %h expected 0", Z); end
    n_cmp++; if (Z_valid !== 1'b0) begin n_bad++; $display("FAIL abort_zvalid: got %b expected 0", Z_valid); end
    step;
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 50; i++) begin
      step;
      if (Z_valid) pulses++;
    end
    n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL abort_no_valid: got %0d expected 0", pulses); end
    run_job(VEC3, 3, 0, 0, 40, lat, pulses, zc, dz);
    n_cmp++; if (lat !== 36) begin n_bad++; $display("FAIL post_rst_latency: got %0d expected 36", lat); end
    n_cmp++; if (zc !== EXP3) begin n_bad++; $display("FAIL post_rst_z: got %h expected %h", zc, EXP3); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_vector3;
    test_busy_ignore;
    test_back_to_back;
    test_divz_clken;
    test_rst_abort;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
